ex_div: RTL and testbench



---
 rtl/ex_div.sv | 140 ++++++++++++++
 tb/tb_ex_div.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// ex_div: 32-cycle radix-2 restoring divider for the EX stage, stalling IF..EX while busy.
// Optional macro DIV_SIGNED_EN builds signed (DIV) support; undefined means every division is DIVU.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_for_ex
);

    localparam int DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [64:0] sr_q;       // {partial remainder, dividend bits / quotient bits}
    logic [31:0] divisor_q;

    logic [31:0] abs_op1, abs_op2;
    logic [64:0] shifted;
    logic [33:0] diff;
    logic [64:0] sr_d;
    logic [31:0] quo_raw, rem_raw, quo_fix, rem_fix;

`ifdef DIV_SIGNED_EN
    logic neg_quo_q, neg_rem_q;
    logic op1_neg, op2_neg;

    assign op1_neg = signed_div_i & opdata1_i[31];
    assign op2_neg = signed_div_i & opdata2_i[31];
    assign abs_op1 = op1_neg ? -opdata1_i : opdata1_i;
    assign abs_op2 = op2_neg ? -opdata2_i : opdata2_i;
    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    assign quo_fix = neg_quo_q ? -quo_raw : quo_raw;
    assign rem_fix = neg_rem_q ? -rem_raw : rem_raw;
`else
    logic unused_signed;

    assign unused_signed = signed_div_i;
    assign abs_op1       = opdata1_i;
    assign abs_op2       = opdata2_i;
    assign quo_fix       = quo_raw;
    assign rem_fix       = rem_raw;
`endif

    // One restoring step: shift, trial-subtract, keep the difference if it did not borrow.
    always_comb begin
        shifted = sr_q << 1;
        diff    = {1'b0, shifted[64:32]} - {2'b0, divisor_q};
        sr_d    = shifted;
        if (!diff[33]) begin
            sr_d[64:32] = diff[32:0];
            sr_d[0]     = 1'b1;
        end
    end

    assign quo_raw = sr_d[31:0];
    assign rem_raw = sr_d[63:32];

    // NOTE: the stall must be combinational so EX freezes in the very cycle the start is seen.
    assign stallreq_for_ex = !annul_i &&
                             ((state_q == S_FREE && div_start_i) ||
                              state_q == S_ON || state_q == S_BYZERO);

    // NOTE: sequential state uses non-blocking assignments only; the reset branch wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            sr_q      <= '0;
            divisor_q <= '0;
            result_o  <= '0;
            ready_o   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FREE: begin
                    if (div_start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state_q <= S_BYZERO;
                        end else begin
                            state_q   <= S_ON;
                            sr_q      <= {33'd0, abs_op1};
                            divisor_q <= abs_op2;
                            cnt_q     <= '0;
`ifdef DIV_SIGNED_EN
                            neg_quo_q <= op1_neg ^ op2_neg;
                            neg_rem_q <= op1_neg;
`endif
                        end
                    end
                end
                S_BYZERO: begin
                    if (annul_i) begin
                        state_q <= S_FREE;
                    end else begin
                        state_q  <= S_END;
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state_q <= S_FREE;
                    end else begin
                        sr_q  <= sr_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'(DIV_CYCLES - 1)) begin
                            state_q  <= S_END;
                            result_o <= {rem_fix, quo_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                S_END: begin
                    if (!div_start_i) begin
                        state_q <= S_FREE;
                        ready_o <= 1'b0;
                    end
                end
                default: state_q <= S_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed and random divisions checked against an arithmetic reference model.
// Adapts its expectations to the DIV_SIGNED_EN build option.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_for_ex;

    int errors = 0;
    int checks = 0;

    ex_div dut (
        .clk             (clk),
        .rst             (rst),
        .div_start_i     (div_start_i),
        .signed_div_i    (signed_div_i),
        .opdata1_i       (opdata1_i),
        .opdata2_i       (opdata2_i),
        .annul_i         (annul_i),
        .result_o        (result_o),
        .ready_o         (ready_o),
        .stallreq_for_ex (stallreq_for_ex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; by-zero yields 0, remainder keeps dividend sign.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        sa = longint'(a);
        sb = longint'(b);
`ifdef DIV_SIGNED_EN
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
`else
        if (sgn) sa = longint'(a);
`endif
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Runs one division from FREE and checks stall window, latency, result and hold behaviour.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [63:0] exp, input string tag);
        int  lat;
        logic ok_stall, ok_ready;
        lat      = (b == 32'd0) ? 2 : 33;
        ok_stall = 1'b1;
        ok_ready = 1'b1;
        @(negedge clk);
        div_start_i  = 1'b1;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        #1;
        check({tag, " stall c0"}, stallreq_for_ex, 1);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            if (k == 5) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                #1;
            end
            if (!stallreq_for_ex) ok_stall = 1'b0;
            if (ready_o) ok_ready = 1'b0;
        end
        check({tag, " stall window"}, ok_stall, 1);
        check({tag, " ready early"}, ok_ready, 1);
        @(negedge clk);
        check({tag, " ready"}, ready_o, 1);
        check({tag, " stall end"}, stallreq_for_ex, 0);
        check({tag, " result"}, result_o, exp);
        @(negedge clk);
        check({tag, " hold ready"}, ready_o, 1);
        check({tag, " hold result"}, result_o, exp);
        div_start_i = 1'b0;
        @(negedge clk);
        check({tag, " ready drop"}, ready_o, 0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        logic [63:0] last_res;

        rst = 1'b1; div_start_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0; annul_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset result", result_o, 0);
        check("reset ready", ready_o, 0);
        check("reset stall", stallreq_for_ex, 0);
        rst = 1'b0;

        do_div(32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, "u100/7");
`ifdef DIV_SIGNED_EN
        do_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, "s-7/2");
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, "ovf");
`else
        do_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'h1, 32'h7FFFFFFC}, "s-7/2");
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h80000000, 32'h0}, "ovf");
`endif
        do_div(32'd5, 32'd0, 1'b0, 64'd0, "div0");
        do_div(32'hFFFFFFFF, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF}, "max/1");
        last_res = 64'd0 | {32'h0, 32'hFFFFFFFF};

        // Annul at cycle 10 of an in-flight division.
        @(negedge clk);
        div_start_i = 1'b1; signed_div_i = 1'b0;
        opdata1_i = 32'd12345; opdata2_i = 32'd11;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        annul_i = 1'b1;
        #1;
        check("annul stall c10", stallreq_for_ex, 0);
        @(negedge clk);
        annul_i = 1'b0;
        div_start_i = 1'b0;
        #1;
        check("annul stall c11", stallreq_for_ex, 0);
        begin
            logic saw_ready;
            saw_ready = 1'b0;
            repeat (30) begin
                @(negedge clk);
                if (ready_o || stallreq_for_ex) saw_ready = 1'b1;
            end
            check("annul no ready", saw_ready, 0);
        end
        check("annul result kept", result_o, last_res);
        do_div(32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, "9/3 after annul");

        // Synchronous reset at cycle 20 mid-division.
        @(negedge clk);
        div_start_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        rst = 1'b1;
        div_start_i = 1'b0;
        @(negedge clk);
        check("midrst result", result_o, 0);
        check("midrst ready", ready_o, 0);
        check("midrst stall", stallreq_for_ex, 0);
        rst = 1'b0;
        do_div(32'd1000, 32'd3, 1'b0, {32'h1, 32'd333}, "1000/3 after rst");

        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (i % 4 == 1) b = -b;
            s = 1'($urandom_range(0, 1));
            do_div(a, b, s, model(a, b, s), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
